// File: rtl/elastic_fifo_buffer.sv
// elastic_fifo_buffer: opaque elastic FIFO slot-buffer for one branch of an eager fork.
// Decouples a stalled consumer from the fork. No combinational path from nReadyArray to
// readyArray, and no same-cycle bypass from input to output.
//
// Ports:
//   clk           in   clock, all state on rising edge
//   rstn          in   synchronous reset, active-low
//   dataInArray   in   token data from upstream
//   pValidArray   in   upstream token valid
//   readyArray    out  buffer can accept a token this cycle
//   dataOutArray  out  head-of-queue data (don't-care while validArray=0)
//   validArray    out  head-of-queue valid
//   nReadyArray   in   downstream ready
//   occupancy     out  number of stored tokens (0..DEPTH), registered
module elastic_fifo_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DATA_SIZE = 8,
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [DATA_SIZE-1:0] dataInArray,
  input  logic                 pValidArray,
  output logic                 readyArray,
  output logic [DATA_SIZE-1:0] dataOutArray,
  output logic                 validArray,
  input  logic                 nReadyArray,
  output logic [CNT_W-1:0]     occupancy
);

  // A single-slot buffer still needs a 1-bit pointer to keep the declarations legal.
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 push, pop;

  always_comb begin
    // Handshakes are masked while reset is asserted so nothing moves in the reset cycle.
    readyArray   = rstn && (count_q != CNT_W'(DEPTH));
    validArray   = rstn && (count_q != '0);
    dataOutArray = mem_q[rd_ptr_q];
    occupancy    = count_q;

    push = pValidArray && readyArray;
    pop  = validArray && nReadyArray;

    // Explicit wrap so non-power-of-two depths work.
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end

    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; push is already suppressed during reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= dataInArray;
    end
  end

endmodule

// File: tb/tb_elastic_fifo_buffer.sv
module tb_elastic_fifo_buffer;

  logic       clk;
  logic       rstn;
  logic [7:0] din;
  logic       pv_a, nr_a, ready_a, valid_a;
  logic [7:0] dout_a;
  logic [2:0] occ_a;
  logic       pv_b, nr_b, ready_b, valid_b;
  logic [7:0] dout_b;
  logic [1:0] occ_b;

  int tests;
  int failed;
  int obs_pops;
  bit accepted;
  logic [7:0] q[$];

  elastic_fifo_buffer #(.DEPTH(4), .DATA_SIZE(8)) u_dut4 (
    .clk          (clk),
    .rstn         (rstn),
    .dataInArray  (din),
    .pValidArray  (pv_a),
    .readyArray   (ready_a),
    .dataOutArray (dout_a),
    .validArray   (valid_a),
    .nReadyArray  (nr_a),
    .occupancy    (occ_a)
  );

  elastic_fifo_buffer #(.DEPTH(3), .DATA_SIZE(8)) u_dut3 (
    .clk          (clk),
    .rstn         (rstn),
    .dataInArray  (din),
    .pValidArray  (pv_b),
    .readyArray   (ready_b),
    .dataOutArray (dout_b),
    .validArray   (valid_b),
    .nReadyArray  (nr_b),
    .occupancy    (occ_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle on the selected DUT (0: DEPTH=4, 1: DEPTH=3); the other stays idle.
  // Outputs are checked at the falling edge against the queue model.
  task automatic cycle(input bit sel, input logic rst_v, input logic pv, input logic [7:0] d,
                       input logic nr);
    logic       exp_ready, exp_valid, obs_r, obs_v;
    logic [7:0] obs_d;
    logic [2:0] obs_o;
    int         depth;
    bit         push, pop;
    rstn = rst_v;
    din  = d;
    pv_a = sel ? 1'b0 : pv;
    nr_a = sel ? 1'b0 : nr;
    pv_b = sel ? pv : 1'b0;
    nr_b = sel ? nr : 1'b0;
    depth = sel ? 3 : 4;
    @(negedge clk);
    obs_r = sel ? ready_b : ready_a;
    obs_v = sel ? valid_b : valid_a;
    obs_d = sel ? dout_b : dout_a;
    obs_o = sel ? {1'b0, occ_b} : occ_a;
    exp_ready = rst_v && (q.size() != depth);
    exp_valid = rst_v && (q.size() != 0);
    chk("ready", 32'(obs_r), 32'(exp_ready));
    chk("valid", 32'(obs_v), 32'(exp_valid));
    chk("occupancy", 32'(obs_o), q.size());
    if (exp_valid) chk("data", 32'(obs_d), 32'(q[0]));
    if (obs_v === 1'b1 && nr) obs_pops++;
    push = pv && exp_ready;
    pop  = exp_valid && nr;
    @(posedge clk);
    #1;
    accepted = push;
    if (!rst_v) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
    end
  endtask

  initial begin
    int nxt;
    logic pv_r, nr_r;
    tests    = 0;
    failed   = 0;
    obs_pops = 0;
    rstn = 1'b0;
    din  = '0;
    pv_a = 1'b0;
    nr_a = 1'b0;
    pv_b = 1'b0;
    nr_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    cycle(0, 1, 0, 8'h00, 0);

    // Fill with downstream stalled, then an extra token that must be refused
    cycle(0, 1, 1, 8'h11, 0);
    cycle(0, 1, 1, 8'h22, 0);
    cycle(0, 1, 1, 8'h33, 0);
    cycle(0, 1, 1, 8'h44, 0);
    cycle(0, 1, 1, 8'h55, 0);
    cycle(0, 1, 1, 8'h55, 0);

    // Drain in order
    repeat (4) cycle(0, 1, 0, 8'h00, 1);
    cycle(0, 1, 0, 8'h00, 1);

    // Simultaneous push and pop at occupancy 2
    cycle(0, 1, 1, 8'hA1, 0);
    cycle(0, 1, 1, 8'hA2, 0);
    cycle(0, 1, 1, 8'hA3, 1);
    chk("t4_occ_after_pushpop", 32'(occ_a), 2);
    cycle(0, 1, 0, 8'h00, 0);
    repeat (2) cycle(0, 1, 0, 8'h00, 1);
    cycle(0, 1, 0, 8'h00, 0);

    // Reset mid-stream at occupancy 3
    cycle(0, 1, 1, 8'hB1, 0);
    cycle(0, 1, 1, 8'hB2, 0);
    cycle(0, 1, 1, 8'hB3, 0);
    cycle(0, 0, 1, 8'hB4, 1);
    cycle(0, 1, 0, 8'h00, 1);
    cycle(0, 1, 1, 8'h77, 1);
    chk("t6_first_token", 32'(dout_a), 32'h77);
    cycle(0, 1, 0, 8'h00, 1);
    cycle(0, 1, 0, 8'h00, 1);

    // Wrap on DEPTH=3 with random handshakes
    nxt = 0;
    obs_pops = 0;
    for (int i = 0; i < 600 && obs_pops < 20; i++) begin
      pv_r = (nxt < 20) && ($urandom_range(0, 1) == 1);
      nr_r = ($urandom_range(0, 1) == 1);
      cycle(1, 1, pv_r, nxt[7:0], nr_r);
      if (accepted) nxt++;
    end
    chk("t5_tokens_out", obs_pops, 20);
    chk("t5_tokens_in", nxt, 20);
    cycle(1, 1, 0, 8'h00, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
